sl_tx_feeder: RTL and testbench

Upstream feeder for the SL transmitter. It buffers 32-bit words and their per-word mode from the bridge's bus-side write logic in a small FIFO. It hands words one at a time to the SL transmitter over a data/enable/ready handshake and enforces a minimum idle gap between words on the line. It also reports FIFO level, overflow and handshake-timeout errors.

---
 rtl/sl_pkg.sv | 19 +
 rtl/sl_sync_fifo.sv | 61 ++++++
 rtl/sl_tx_feeder.sv | 140 ++++++++++++++
 tb/tb_sl_tx_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - shared types for the SL transmit feeder and its FIFO
package sl_pkg;

  typedef logic [1:0]  sl_mode_t;
  typedef logic [31:0] sl_word_t;

  // Mode sits above data so a packed entry reads as {mode, data}
  typedef struct packed {
    sl_mode_t mode;
    sl_word_t data;
  } sl_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sl_sync_fifo.sv
// rtl/sl_sync_fifo.sv - single-clock FIFO with level count, first-word-fall-through head
module sl_sync_fifo
  import sl_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = sl_entry_t,
  parameter int  AW      = $clog2(DEPTH),
  parameter int  LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flags come from the registered level, so a push against a full FIFO is
  // refused even when a pop frees a slot on the same edge.
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sl_tx_feeder.sv
// rtl/sl_tx_feeder.sv - buffers words and paces them into the SL transmitter
module sl_tx_feeder
  import sl_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  input  logic [1:0]             wr_mode,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            tx_data,
  output logic [1:0]             tx_mode,
  output logic                   tx_enable,
  input  logic                   tx_ready,
  output logic                   overflow,
  output logic                   timeout,
  input  logic                   clr_err
);

  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES);
  localparam logic [15:0] TOUT_LOAD = 16'(ACK_TIMEOUT);

  feeder_state_t state, state_d;
  logic [7:0]    gap_cnt, gap_d;
  logic [15:0]   tout_cnt, tout_d;
  logic          tx_enable_d;
  sl_word_t      tx_data_d;
  sl_mode_t      tx_mode_d;
  logic          fifo_pop;
  logic          tout_evt;
  sl_entry_t     push_entry;
  sl_entry_t     head;

  assign push_entry = '{mode: wr_mode, data: wr_data};

  sl_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (sl_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Handshake sequencing: pace pops by the idle gap, then watch for acceptance
  always_comb begin
    state_d     = state;
    gap_d       = gap_cnt;
    tout_d      = tout_cnt;
    tx_enable_d = tx_enable;
    tx_data_d   = tx_data;
    tx_mode_d   = tx_mode;
    fifo_pop    = 1'b0;
    tout_evt    = 1'b0;
    case (state)
      IDLE: begin
        // A low tx_ready here just freezes the gap; nothing is popped
        if (tx_ready) begin
          if (gap_cnt != '0) begin
            gap_d = gap_cnt - 8'd1;
          end else if (!empty) begin
            fifo_pop    = 1'b1;
            tx_data_d   = head.data;
            tx_mode_d   = head.mode;
            tx_enable_d = 1'b1;
            tout_d      = TOUT_LOAD;
            state_d     = START;
          end
        end
      end
      START: begin
        if (!tx_ready) begin
          tx_enable_d = 1'b0;
          state_d     = BUSY;
        end else if (tout_cnt <= 16'd1) begin
          // Last allowed cycle expired: abandon the word
          tx_enable_d = 1'b0;
          tout_d      = '0;
          tout_evt    = 1'b1;
          gap_d       = GAP_LOAD;
          state_d     = IDLE;
        end else begin
          tout_d = tout_cnt - 16'd1;
        end
      end
      BUSY: begin
        if (tx_ready) begin
          gap_d   = GAP_LOAD;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the word presented to the transmitter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= GAP_LOAD;
      tout_cnt  <= '0;
      tx_enable <= 1'b0;
      tx_data   <= '0;
      tx_mode   <= '0;
    end else begin
      state     <= state_d;
      gap_cnt   <= gap_d;
      tout_cnt  <= tout_d;
      tx_enable <= tx_enable_d;
      tx_data   <= tx_data_d;
      tx_mode   <= tx_mode_d;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (tout_evt)      timeout  <= 1'b1;
      else if (clr_err)  timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sl_tx_feeder.sv
// tb/tb_sl_tx_feeder.sv - directed self-checking bench for sl_tx_feeder
module tb_sl_tx_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_mode;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic [31:0] tx_data;
  logic [1:0]  tx_mode;
  logic        tx_enable;
  logic        tx_ready;
  logic        overflow;
  logic        timeout;
  logic        clr_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sl_tx_feeder #(
    .DEPTH       (8),
    .GAP_CYCLES  (4),
    .ACK_TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_mode   (wr_mode),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .tx_data   (tx_data),
    .tx_mode   (tx_mode),
    .tx_enable (tx_enable),
    .tx_ready  (tx_ready),
    .overflow  (overflow),
    .timeout   (timeout),
    .clr_err   (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] m);
    wr_en   = 1'b1;
    wr_data = d;
    wr_mode = m;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_enable(input string tag, input int limit);
    int w;
    w = 0;
    while (!tx_enable && w < limit) begin
      tick(1);
      w++;
    end
    check(tag, 32'(tx_enable), 32'd1);
  endtask

  // Transmitter model: drop ready 2 cycles after enable, hold busy, restore
  task automatic serve_word(input string tag, input int busy_len,
                            output logic [31:0] d, output logic [1:0] m);
    wait_enable(tag, 100);
    d = tx_data;
    m = tx_mode;
    tick(2);
    tx_ready = 1'b0;
    tick(busy_len);
    tx_ready = 1'b1;
  endtask

  // Edges from the one sampling tx_ready high to the one raising tx_enable
  task automatic measure_gap(output int n);
    tick(1);
    n = 0;
    while (!tx_enable && n < 50) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  m;
    logic [31:0] da, db, dc;
    int          g1, g2, hi;
    logic        stable, seen;

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_mode = '0;
    tx_ready = 1'b1; clr_err = 1'b0;
    tick(2);
    check("rst_level",    32'(level),     32'd0);
    check("rst_empty",    32'(empty),     32'd1);
    check("rst_full",     32'(full),      32'd0);
    check("rst_enable",   32'(tx_enable), 32'd0);
    check("rst_data",     tx_data,        32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_timeout",  32'(timeout),   32'd0);

    // Single word: latency, stability through BUSY, drain
    reset = 1'b0;
    tick(6);
    push_word(32'd2134, 2'b01);
    check("t1_no_early_en", 32'(tx_enable), 32'd0);
    check("t1_level_push",  32'(level),     32'd1);
    tick(1);
    check("t1_en_rise", 32'(tx_enable), 32'd1);
    check("t1_data",    tx_data,        32'd2134);
    check("t1_mode",    32'(tx_mode),   32'd1);
    check("t1_level0",  32'(level),     32'd0);
    tick(2);
    tx_ready = 1'b0;
    tick(1);
    check("t1_en_drop", 32'(tx_enable), 32'd0);
    stable = 1'b1;
    repeat (39) begin
      tick(1);
      if (tx_data !== 32'd2134 || tx_mode !== 2'b01 || tx_enable !== 1'b0) stable = 1'b0;
    end
    check("t1_busy_stable", 32'(stable), 32'd1);
    tx_ready = 1'b1;
    tick(1);
    check("t1_level_end", 32'(level), 32'd0);
    check("t1_empty_end", 32'(empty), 32'd1);

    // Three words in order with a 5-edge turnaround
    push_word(32'hAAAA_0001, 2'b00);
    push_word(32'hBBBB_0002, 2'b01);
    push_word(32'hCCCC_0003, 2'b10);
    serve_word("t2_wait_a", 10, da, m);
    measure_gap(g1);
    serve_word("t2_wait_b", 10, db, m);
    measure_gap(g2);
    serve_word("t2_wait_c", 10, dc, m);
    check("t2_word_a", da, 32'hAAAA_0001);
    check("t2_word_b", db, 32'hBBBB_0002);
    check("t2_word_c", dc, 32'hCCCC_0003);
    check("t2_gap_b",  32'(g1), 32'd5);
    check("t2_gap_c",  32'(g2), 32'd5);

    // Fill to full with the transmitter held busy, then overflow
    tick(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + 32'(i), 2'(i));
    check("t3_full",      32'(full),     32'd1);
    check("t3_level8",    32'(level),    32'd8);
    check("t3_no_ovf",    32'(overflow), 32'd0);
    push_word(32'h9999_0009, 2'b11);
    check("t3_ovf",       32'(overflow), 32'd1);
    check("t3_level_ovf", 32'(level),    32'd8);

    // Push against full on the pop edge, with clr_err in the same cycle
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t6_ovf_clr", 32'(overflow), 32'd0);
    tx_ready = 1'b1;
    tick(4);
    wr_en = 1'b1; wr_data = 32'h6666_0006; wr_mode = 2'b10; clr_err = 1'b1;
    tick(1);
    wr_en = 1'b0; clr_err = 1'b0;
    check("t6_ovf",   32'(overflow),  32'd1);
    check("t6_level", 32'(level),     32'd7);
    check("t6_en",    32'(tx_enable), 32'd1);
    for (int i = 0; i < 8; i++) begin
      serve_word("t3_wait", 3, d, m);
      check("t3_drain_data", d, 32'h1000_0000 + 32'(i));
      check("t3_drain_mode", 32'(m), 32'(i % 4));
    end
    seen = 1'b0;
    repeat (20) begin
      tick(1);
      if (tx_enable) seen = 1'b1;
    end
    check("t3_no_extra_word", 32'(seen),  32'd0);
    check("t3_level_end",     32'(level), 32'd0);

    // Transmitter never accepts: enable width and timeout flag
    push_word(32'hDEAD_0004, 2'b10);
    tick(1);
    check("t4_en_rise", 32'(tx_enable), 32'd1);
    hi = 0;
    while (tx_enable && hi < 200) begin
      hi++;
      tick(1);
    end
    check("t4_en_cycles",  32'(hi),       32'd64);
    check("t4_timeout",    32'(timeout),  32'd1);
    check("t4_level",      32'(level),    32'd0);
    check("t4_empty",      32'(empty),    32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t4_timeout_clr", 32'(timeout),  32'd0);
    check("t4_ovf_clr",     32'(overflow), 32'd0);

    // Reset while BUSY with three words still queued
    for (int i = 0; i < 4; i++) push_word(32'h5555_0000 + 32'(i), 2'b01);
    wait_enable("t5_wait", 100);
    check("t5_first", tx_data, 32'h5555_0000);
    tick(2);
    tx_ready = 1'b0;
    tick(3);
    check("t5_level_busy", 32'(level), 32'd3);
    reset = 1'b1;
    tick(1);
    check("t5_en",    32'(tx_enable), 32'd0);
    check("t5_level", 32'(level),     32'd0);
    check("t5_empty", 32'(empty),     32'd1);
    check("t5_data",  tx_data,        32'd0);
    reset = 1'b0;
    tx_ready = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick(1);
      if (tx_enable) seen = 1'b1;
    end
    check("t5_no_send",   32'(seen),  32'd0);
    check("t5_level_end", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
